// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, funct3 codes and helpers for the MEM-stage data-memory controller
package dmem_pkg;

    localparam int DEF_TIMEOUT_CYCLES = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Stores only have signed widths; loads additionally allow the unsigned byte/half forms.
    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!is_store) begin
            ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

    // True when the byte address does not sit on the natural boundary of the access width.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        case (f3)
            F3_H, F3_HU: mis = off[0];
            F3_W:        mis = (off != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// rtl/dmem_access_ctrl_if.sv - req/ack data-memory port between the MEM-stage controller and memory
interface dmem_access_ctrl_if;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_ack_i;
    logic [31:0] dmem_rdata_i;

    modport master (
        output dmem_req_o,
        output dmem_we_o,
        output dmem_addr_o,
        output dmem_be_o,
        output dmem_wdata_o,
        input  dmem_ack_i,
        input  dmem_rdata_i
    );

    modport slave (
        input  dmem_req_o,
        input  dmem_we_o,
        input  dmem_addr_o,
        input  dmem_be_o,
        input  dmem_wdata_o,
        output dmem_ack_i,
        output dmem_rdata_i
    );
endinterface

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-enable generation, store-lane replication and load extraction/extension
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] load_ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte and halfword out of the returned word.
    always_comb begin
        byte_sel = rdata[7:0];
        case (off)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    end

    // Width-dependent enables, replicated store data and extended load data; halfword ignores off[0].
    always_comb begin
        be        = 4'b0000;
        wdata_rep = wdata;
        load_ext  = 32'h0;
        case (funct3)
            F3_B: begin
                be        = 4'b0001 << off;
                wdata_rep = {4{wdata[7:0]}};
                load_ext  = {{24{byte_sel[7]}}, byte_sel};
            end
            F3_BU: begin
                be        = 4'b0001 << off;
                wdata_rep = {4{wdata[7:0]}};
                load_ext  = {24'h0, byte_sel};
            end
            F3_H: begin
                be        = 4'b0011 << {off[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
                load_ext  = {{16{half_sel[15]}}, half_sel};
            end
            F3_HU: begin
                be        = 4'b0011 << {off[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
                load_ext  = {16'h0, half_sel};
            end
            F3_W: begin
                be        = 4'b1111;
                wdata_rep = wdata;
                load_ext  = rdata;
            end
            default: begin
                be        = 4'b0000;
                wdata_rep = wdata;
                load_ext  = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - MEM-stage load/store sequencer with stall and timeout; optional DMEM_MISALIGN_TRAP_EN
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W          = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read_i,
    input  logic                  mem_write_i,
    input  logic [2:0]            funct3_i,
    input  logic [31:0]           addr_i,
    input  logic [31:0]           wdata_i,
    dmem_access_ctrl_if.master    dmem,
    output logic [31:0]           load_data_o,
    output logic                  stall_o,
    output logic                  err_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       f3_q;
    logic [1:0]       off_q;

    logic             access;
    logic             bad_f3;
    logic             mis_trap;
    logic [2:0]       sel_f3;
    logic [1:0]       sel_off;
    logic [3:0]       be_c;
    logic [31:0]      wdata_c;
    logic [31:0]      load_c;

    assign access = mem_read_i | mem_write_i;
    assign bad_f3 = !f3_legal(mem_write_i, funct3_i);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign mis_trap = misaligned(funct3_i, addr_i[1:0]);
`else
    assign mis_trap = 1'b0;
`endif

    // Stall starts the cycle the access shows up and covers every REQ cycle; DONE lets EX/MEM advance.
    assign stall_o = ((state == IDLE) && access) || (state == REQ);

    // The single lane aligner sees live inputs in IDLE (store side) and the latched access afterwards (load side).
    assign sel_f3  = (state == IDLE) ? funct3_i    : f3_q;
    assign sel_off = (state == IDLE) ? addr_i[1:0] : off_q;

    dmem_lane_align u_align (
        .funct3    (sel_f3),
        .off       (sel_off),
        .wdata     (wdata_i),
        .rdata     (dmem.dmem_rdata_i),
        .be        (be_c),
        .wdata_rep (wdata_c),
        .load_ext  (load_c)
    );

    // Access sequencer: all bus and result outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            cnt               <= '0;
            f3_q              <= 3'b000;
            off_q             <= 2'b00;
            dmem.dmem_req_o   <= 1'b0;
            dmem.dmem_we_o    <= 1'b0;
            dmem.dmem_addr_o  <= 32'h0;
            dmem.dmem_be_o    <= 4'b0000;
            dmem.dmem_wdata_o <= 32'h0;
            load_data_o       <= 32'h0;
            err_o             <= 1'b0;
        end else begin
            err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (access) begin
                        f3_q  <= funct3_i;
                        off_q <= addr_i[1:0];
                        if (bad_f3 || mis_trap) begin
                            // Nothing reaches memory; report the fault in DONE with a zero result.
                            state       <= DONE;
                            err_o       <= 1'b1;
                            load_data_o <= 32'h0;
                        end else begin
                            state             <= REQ;
                            cnt               <= '0;
                            dmem.dmem_req_o   <= 1'b1;
                            dmem.dmem_we_o    <= mem_write_i;
                            dmem.dmem_addr_o  <= {addr_i[31:2], 2'b00};
                            dmem.dmem_be_o    <= be_c;
                            dmem.dmem_wdata_o <= wdata_c;
                        end
                    end
                end
                REQ: begin
                    if (dmem.dmem_ack_i) begin
                        state           <= DONE;
                        dmem.dmem_req_o <= 1'b0;
                        dmem.dmem_we_o  <= 1'b0;
                        if (!dmem.dmem_we_o) begin
                            load_data_o <= load_c;
                        end
                    end else if (cnt == CNT_LAST) begin
                        state           <= DONE;
                        dmem.dmem_req_o <= 1'b0;
                        dmem.dmem_we_o  <= 1'b0;
                        err_o           <= 1'b1;
                        load_data_o     <= 32'h0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - directed self-checking bench for dmem_access_ctrl
module tb_dmem_access_ctrl;

    logic        clk;
    logic        rst;
    logic        mem_read_i;
    logic        mem_write_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] load_data_o;
    logic        stall_o;
    logic        err_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    dmem_access_ctrl_if dmem ();

    dmem_access_ctrl #(
        .TIMEOUT_CYCLES (16),
        .CNT_W          (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_read_i  (mem_read_i),
        .mem_write_i (mem_write_i),
        .funct3_i    (funct3_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .dmem        (dmem),
        .load_data_o (load_data_o),
        .stall_o     (stall_o),
        .err_o       (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Results of the most recent access driven by do_access.
    int          r_done;
    int          r_stall;
    int          r_req;
    logic        r_err;
    logic [31:0] r_load;
    logic        r_we;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;

    // Drive one access, acking after ack_after REQ cycles (-1 = never); stop at the first non-stall cycle.
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd,
                             input int ack_after, input logic [31:0] rdata);
        r_done = 0; r_stall = 0; r_req = 0; r_err = 1'b0; r_load = 32'h0;
        r_we = 1'b0; r_addr = 32'h0; r_be = 4'h0; r_wdata = 32'h0;
        @(posedge clk); #1;
        mem_read_i = rd; mem_write_i = wr; funct3_i = f3; addr_i = a; wdata_i = wd;
        dmem.dmem_ack_i = 1'b0;
        for (int cyc = 0; cyc < 64; cyc++) begin
            @(negedge clk);
            if (!stall_o) begin
                r_done = 1;
                r_err  = err_o;
                r_load = load_data_o;
                dmem.dmem_ack_i = 1'b0;
                break;
            end
            r_stall++;
            if (dmem.dmem_req_o) begin
                if (r_req == 0) begin
                    r_we = dmem.dmem_we_o; r_addr = dmem.dmem_addr_o;
                    r_be = dmem.dmem_be_o; r_wdata = dmem.dmem_wdata_o;
                end
                if (r_req == ack_after) begin
                    dmem.dmem_ack_i = 1'b1; dmem.dmem_rdata_i = rdata;
                end else begin
                    dmem.dmem_ack_i = 1'b0; dmem.dmem_rdata_i = 32'h5A5A5A5A;
                end
                r_req++;
            end else begin
                dmem.dmem_ack_i = 1'b0;
            end
        end
        @(posedge clk); #1;
        mem_read_i = 1'b0; mem_write_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total_cnt++; if (dmem.dmem_req_o !== 1'b0) $display("FAIL reset_req: got %b expected 0", dmem.dmem_req_o); else pass_cnt++;
        total_cnt++; if (dmem.dmem_we_o !== 1'b0) $display("FAIL reset_we: got %b expected 0", dmem.dmem_we_o); else pass_cnt++;
        total_cnt++; if (dmem.dmem_be_o !== 4'h0) $display("FAIL reset_be: got %h expected 0", dmem.dmem_be_o); else pass_cnt++;
        total_cnt++; if (dmem.dmem_addr_o !== 32'h0) $display("FAIL reset_addr: got %h expected 0", dmem.dmem_addr_o); else pass_cnt++;
        total_cnt++; if (dmem.dmem_wdata_o !== 32'h0) $display("FAIL reset_wdata: got %h expected 0", dmem.dmem_wdata_o); else pass_cnt++;
        total_cnt++; if (load_data_o !== 32'h0) $display("FAIL reset_load: got %h expected 0", load_data_o); else pass_cnt++;
        total_cnt++; if (err_o !== 1'b0) $display("FAIL reset_err: got %b expected 0", err_o); else pass_cnt++;
        total_cnt++; if (stall_o !== 1'b0) $display("FAIL reset_stall: got %b expected 0", stall_o); else pass_cnt++;
    endtask

    task automatic test_sw();
        do_access(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 32'h0);
        total_cnt++; if (r_done !== 1) $display("FAIL sw_done: got %0d expected 1", r_done); else pass_cnt++;
        total_cnt++; if (r_req !== 1) $display("FAIL sw_req_cycles: got %0d expected 1", r_req); else pass_cnt++;
        total_cnt++; if (r_we !== 1'b1) $display("FAIL sw_we: got %b expected 1", r_we); else pass_cnt++;
        total_cnt++; if (r_addr !== 32'h100) $display("FAIL sw_addr: got %h expected 00000100", r_addr); else pass_cnt++;
        total_cnt++; if (r_be !== 4'b1111) $display("FAIL sw_be: got %b expected 1111", r_be); else pass_cnt++;
        total_cnt++; if (r_wdata !== 32'hDEADBEEF) $display("FAIL sw_wdata: got %h expected deadbeef", r_wdata); else pass_cnt++;
        total_cnt++; if (r_stall !== 2) $display("FAIL sw_stall: got %0d expected 2", r_stall); else pass_cnt++;
        total_cnt++; if (r_err !== 1'b0) $display("FAIL sw_err: got %b expected 0", r_err); else pass_cnt++;
    endtask

    task automatic test_loads();
        do_access(1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 3, 32'h80FF0011);
        total_cnt++; if (r_we !== 1'b0) $display("FAIL lb_we: got %b expected 0", r_we); else pass_cnt++;
        total_cnt++; if (r_addr !== 32'h200) $display("FAIL lb_addr: got %h expected 00000200", r_addr); else pass_cnt++;
        total_cnt++; if (r_be !== 4'b1000) $display("FAIL lb_be: got %b expected 1000", r_be); else pass_cnt++;
        total_cnt++; if (r_load !== 32'hFFFFFF80) $display("FAIL lb_load: got %h expected ffffff80", r_load); else pass_cnt++;
        total_cnt++; if (r_stall !== 5) $display("FAIL lb_stall: got %0d expected 5", r_stall); else pass_cnt++;
        total_cnt++; if (r_err !== 1'b0) $display("FAIL lb_err: got %b expected 0", r_err); else pass_cnt++;

        do_access(1'b1, 1'b0, 3'b101, 32'h202, 32'h0, 0, 32'h80FF0011);
        total_cnt++; if (r_be !== 4'b1100) $display("FAIL lhu_be: got %b expected 1100", r_be); else pass_cnt++;
        total_cnt++; if (r_load !== 32'h000080FF) $display("FAIL lhu_load: got %h expected 000080ff", r_load); else pass_cnt++;

        do_access(1'b1, 1'b0, 3'b001, 32'h200, 32'h0, 0, 32'h80FF8001);
        total_cnt++; if (r_load !== 32'hFFFF8001) $display("FAIL lh_load: got %h expected ffff8001", r_load); else pass_cnt++;

        do_access(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 1, 32'h12345678);
        total_cnt++; if (r_load !== 32'h12345678) $display("FAIL lw_load: got %h expected 12345678", r_load); else pass_cnt++;
        total_cnt++; if (r_stall !== 3) $display("FAIL lw_stall: got %0d expected 3", r_stall); else pass_cnt++;
    endtask

    task automatic test_sb();
        do_access(1'b0, 1'b1, 3'b000, 32'h301, 32'h000000AB, 0, 32'h0);
        total_cnt++; if (r_be !== 4'b0010) $display("FAIL sb_be: got %b expected 0010", r_be); else pass_cnt++;
        total_cnt++; if (r_wdata !== 32'hABABABAB) $display("FAIL sb_wdata: got %h expected abababab", r_wdata); else pass_cnt++;
        total_cnt++; if (r_addr !== 32'h300) $display("FAIL sb_addr: got %h expected 00000300", r_addr); else pass_cnt++;
        // Both MemRead and MemWrite high is a store.
        do_access(1'b1, 1'b1, 3'b001, 32'h402, 32'h0000BEEF, 0, 32'h0);
        total_cnt++; if (r_we !== 1'b1) $display("FAIL both_we: got %b expected 1", r_we); else pass_cnt++;
        total_cnt++; if (r_wdata !== 32'hBEEFBEEF) $display("FAIL sh_wdata: got %h expected beefbeef", r_wdata); else pass_cnt++;
    endtask

    task automatic test_timeout();
        do_access(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, -1, 32'h0);
        total_cnt++; if (r_done !== 1) $display("FAIL to_done: got %0d expected 1", r_done); else pass_cnt++;
        total_cnt++; if (r_req !== 16) $display("FAIL to_req_cycles: got %0d expected 16", r_req); else pass_cnt++;
        total_cnt++; if (r_stall !== 17) $display("FAIL to_stall: got %0d expected 17", r_stall); else pass_cnt++;
        total_cnt++; if (r_err !== 1'b1) $display("FAIL to_err: got %b expected 1", r_err); else pass_cnt++;
        total_cnt++; if (r_load !== 32'h0) $display("FAIL to_load: got %h expected 0", r_load); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (err_o !== 1'b0) $display("FAIL to_err_pulse: got %b expected 0", err_o); else pass_cnt++;
    endtask

    task automatic test_illegal_f3();
        do_access(1'b1, 1'b0, 3'b011, 32'h600, 32'h0, 0, 32'h11111111);
        total_cnt++; if (r_req !== 0) $display("FAIL ill_ld_req: got %0d expected 0", r_req); else pass_cnt++;
        total_cnt++; if (r_stall !== 1) $display("FAIL ill_ld_stall: got %0d expected 1", r_stall); else pass_cnt++;
        total_cnt++; if (r_err !== 1'b1) $display("FAIL ill_ld_err: got %b expected 1", r_err); else pass_cnt++;
        do_access(1'b0, 1'b1, 3'b100, 32'h600, 32'h0, 0, 32'h0);
        total_cnt++; if (r_req !== 0) $display("FAIL ill_st_req: got %0d expected 0", r_req); else pass_cnt++;
        total_cnt++; if (r_err !== 1'b1) $display("FAIL ill_st_err: got %b expected 1", r_err); else pass_cnt++;
    endtask

    task automatic test_nonmem_hold();
        do_access(1'b1, 1'b0, 3'b100, 32'h701, 32'h0, 0, 32'h0000C300);
        total_cnt++; if (r_load !== 32'h000000C3) $display("FAIL lbu_load: got %h expected 000000c3", r_load); else pass_cnt++;
        @(posedge clk); #1;
        dmem.dmem_ack_i = 1'b1; dmem.dmem_rdata_i = 32'hFFFFFFFF;
        repeat (3) @(negedge clk);
        total_cnt++; if (stall_o !== 1'b0) $display("FAIL idle_stall: got %b expected 0", stall_o); else pass_cnt++;
        total_cnt++; if (dmem.dmem_req_o !== 1'b0) $display("FAIL idle_req: got %b expected 0", dmem.dmem_req_o); else pass_cnt++;
        total_cnt++; if (load_data_o !== 32'h000000C3) $display("FAIL idle_hold: got %h expected 000000c3", load_data_o); else pass_cnt++;
        dmem.dmem_ack_i = 1'b0;
    endtask

    task automatic test_reset_mid_req();
        @(posedge clk); #1;
        mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h800; dmem.dmem_ack_i = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        total_cnt++; if (dmem.dmem_req_o !== 1'b1) $display("FAIL mid_req_first: got %b expected 1", dmem.dmem_req_o); else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b1; mem_read_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total_cnt++; if (dmem.dmem_req_o !== 1'b0) $display("FAIL mid_rst_req: got %b expected 0", dmem.dmem_req_o); else pass_cnt++;
        total_cnt++; if (stall_o !== 1'b0) $display("FAIL mid_rst_stall: got %b expected 0", stall_o); else pass_cnt++;
        total_cnt++; if (dmem.dmem_addr_o !== 32'h0) $display("FAIL mid_rst_addr: got %h expected 0", dmem.dmem_addr_o); else pass_cnt++;
        total_cnt++; if (dmem.dmem_be_o !== 4'h0) $display("FAIL mid_rst_be: got %h expected 0", dmem.dmem_be_o); else pass_cnt++;
        total_cnt++; if (load_data_o !== 32'h0) $display("FAIL mid_rst_load: got %h expected 0", load_data_o); else pass_cnt++;
        dmem.dmem_ack_i = 1'b1; dmem.dmem_rdata_i = 32'hCAFEF00D;
        @(negedge clk);
        dmem.dmem_ack_i = 1'b0;
        @(negedge clk);
        total_cnt++; if (load_data_o !== 32'h0) $display("FAIL late_ack_load: got %h expected 0", load_data_o); else pass_cnt++;
        total_cnt++; if (err_o !== 1'b0) $display("FAIL late_ack_err: got %b expected 0", err_o); else pass_cnt++;
    endtask

    task automatic test_misalign();
        do_access(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 0, 32'h76543210);
`ifdef DMEM_MISALIGN_TRAP_EN
        total_cnt++; if (r_req !== 0) $display("FAIL mis_req: got %0d expected 0", r_req); else pass_cnt++;
        total_cnt++; if (r_err !== 1'b1) $display("FAIL mis_err: got %b expected 1", r_err); else pass_cnt++;
        total_cnt++; if (r_stall !== 1) $display("FAIL mis_stall: got %0d expected 1", r_stall); else pass_cnt++;
        total_cnt++; if (r_load !== 32'h0) $display("FAIL mis_load: got %h expected 0", r_load); else pass_cnt++;
`else
        total_cnt++; if (r_req !== 1) $display("FAIL mis_req: got %0d expected 1", r_req); else pass_cnt++;
        total_cnt++; if (r_addr !== 32'h100) $display("FAIL mis_addr: got %h expected 00000100", r_addr); else pass_cnt++;
        total_cnt++; if (r_err !== 1'b0) $display("FAIL mis_err: got %b expected 0", r_err); else pass_cnt++;
        total_cnt++; if (r_load !== 32'h76543210) $display("FAIL mis_load: got %h expected 76543210", r_load); else pass_cnt++;
`endif
    endtask

    initial begin
        rst = 1'b1; mem_read_i = 1'b0; mem_write_i = 1'b0; funct3_i = 3'b000;
        addr_i = 32'h0; wdata_i = 32'h0;
        dmem.dmem_ack_i = 1'b0; dmem.dmem_rdata_i = 32'h0;
        test_reset();
        test_sw();
        test_loads();
        test_sb();
        test_timeout();
        test_illegal_f3();
        test_nonmem_hold();
        test_reset_mid_req();
        test_misalign();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences data-memory accesses for the MEM stage, driven by the EX/MEM pipeline register outputs (RegWrite/MemRead/MemWrite/funct3/ALU result/rd2).
- Converts one load/store per instruction into a req/ack transaction on a variable-latency data-memory port, with byte enables and write-data lane replication.
- Sign/zero-extends load data and asserts stall_o to freeze PC, IF/ID, ID/EX and EX/MEM until the access completes.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles in REQ waiting for dmem_ack_i before abort; legal range 2..255.
- CNT_W, 8: width of the timeout counter; must satisfy TIMEOUT_CYCLES < 2**CNT_W.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- mem_read_i  in  1  EX/MEM MemRead
- mem_write_i  in  1  EX/MEM MemWrite
- funct3_i  in  3  EX/MEM funct3
- addr_i  in  32  EX/MEM ALU result, byte address
- wdata_i  in  32  EX/MEM rd2, store data
- dmem_req_o  out  1  request valid
- dmem_we_o  out  1  1 = write
- dmem_addr_o  out  32  word address, {addr[31:2],2'b00}
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  32  lane-replicated store data
- dmem_ack_i  in  1  request completed; rdata valid same cycle
- dmem_rdata_i  in  32  read word
- load_data_o  out  32  extended load result, to MEM/WB
- stall_o  out  1  freeze upstream pipeline
- err_o  out  1  one-cycle pulse: timeout or illegal funct3

Behaviour:
- FSM states: IDLE, REQ, DONE.
- IDLE, access = mem_read_i | mem_write_i:
  - access=1: latch we (= mem_write_i), funct3, addr, wdata; go to REQ.
  - If both mem_read_i and mem_write_i are high, treat as a write.
  - access=1 with illegal funct3 (load 011/110/111, store 011..111): no request issued; go to DONE with err_o pulsed in DONE.
- REQ:
  - dmem_req_o=1; dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o held stable from latched values.
  - dmem_ack_i=1: capture extended read data, go to DONE.
  - Timeout counter clears on entry and increments each REQ cycle without ack. When it reaches TIMEOUT_CYCLES-1 without ack: go to DONE, load_data 0, err_o=1 in DONE.
  - Ack on the final counted cycle counts as success.
- DONE: stall_o=0, load_data_o valid; EX/MEM advances on this edge; next state IDLE unconditionally.
- stall_o = (IDLE & access) | REQ. It is combinational, so the first stall cycle is the cycle the access appears.
- Latency: zero-wait memory (ack in first REQ cycle) gives 2 stall cycles. Each extra ack wait adds 1.
- Byte enables (off = addr[1:0]):
  - SB: 4'b0001<<off
  - SH: 4'b0011<<{off[1],1'b0}
  - SW: 4'b1111
- Store wdata replication:
  - SB: {4{wdata[7:0]}}
  - SH: {2{wdata[15:0]}}
  - SW: unchanged
- Load extraction: byte lane off (LB/LBU) or halfword lane off[1] (LH/LHU). LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
- Misalignment (feature off): addr[0] ignored for halfword; addr[1:0] ignored for word.
- dmem_ack_i outside REQ is ignored.
- Reset values: state IDLE, counter 0. dmem_req_o, dmem_we_o, dmem_be_o, err_o = 0. dmem_addr_o, dmem_wdata_o, load_data_o = 0.
- Reset mid-REQ: request dropped at that edge; no retry.
- Non-memory instructions: block stays IDLE, stall_o=0, load_data_o holds its last value.

Optional Feature:
- Macro DMEM_MISALIGN_TRAP_EN.
- Defined: in IDLE, LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, issue no request. Go to DONE with err_o=1, load_data_o=0, 1 stall cycle.
- Undefined: misaligned addresses are silently truncated as above.

Decomposition:
- Shared package dmem_pkg:
  - state enum {IDLE, REQ, DONE}
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101
  - default TIMEOUT_CYCLES
- One combinational sub-module, dmem_lane_align: funct3 + offset + wdata/rdata → be, replicated wdata, extended load data. Reused by the bench model.

Test Plan:
- SW addr 0x100, wdata 0xDEADBEEF, ack in first REQ cycle → req/we=1, addr 0x100, be 1111, wdata 0xDEADBEEF; stall high exactly 2 cycles; err_o=0.
- LB addr 0x203, rdata 0x80FF0011, ack after 3 wait cycles → be 1000, load_data_o 0xFFFFFF80, stall 5 cycles.
- LHU addr 0x202, rdata 0x80FF0011 → load_data_o 0x000080FF; SB addr 0x301, wdata 0x000000AB → be 0010, wdata 0xABABABAB.
- No ack, TIMEOUT_CYCLES=16 → req held 16 cycles, then DONE with err_o pulse 1 cycle, load_data_o 0, stall released.
- rst asserted in 2nd REQ cycle → next cycle req=0, stall=0, all outputs at reset values; a late ack is ignored.
- With DMEM_MISALIGN_TRAP_EN: LW addr 0x102 → no req, err_o=1, stall 1 cycle. Without the macro: req issued to 0x100.
